// File: rtl/commit_bus_arbiter.sv
// Commit bus arbiter: grants one reservation station per cycle and broadcasts its registered commit packet.
// Round-robin by default; define COMMIT_ARB_FIXED_PRIO_EN for lowest-index fixed priority.
`ifndef COMMIT_PACKET_SIZE
`define COMMIT_PACKET_SIZE 32
`endif

module commit_bus_arbiter #(
  parameter int unsigned NUM_STATIONS = 4,
  parameter int unsigned PACKET_WIDTH = `COMMIT_PACKET_SIZE,
  parameter int unsigned PTR_WIDTH    = 3
) (
  input  logic                                 Clock,
  input  logic                                 Reset,
  input  logic [NUM_STATIONS-1:0]              iCommitRequest,
  input  logic [NUM_STATIONS*PACKET_WIDTH-1:0] iCommitData,
  input  logic                                 iCommitStall,
  output logic [NUM_STATIONS-1:0]              oCommitGranted,
  output logic [PACKET_WIDTH-1:0]              oCommitBus,
  output logic                                 oCommitValid,
  output logic                                 oBusy
);

  logic [NUM_STATIONS-1:0] eligible_c;
  logic [PTR_WIDTH-1:0]    start_c;
  logic [PTR_WIDTH-1:0]    win_idx_c;
  logic [PTR_WIDTH-1:0]    wrap_idx_c;
  logic                    win_found_c;
  logic                    any_c;
  logic [NUM_STATIONS-1:0] granted_d;
  logic [PACKET_WIDTH-1:0] bus_d;
  logic                    valid_d;

  // A station granted last cycle still shows its request, so mask it out.
  assign eligible_c = iCommitRequest & ~oCommitGranted;
  assign oBusy      = (|iCommitRequest) | oCommitValid;

`ifdef COMMIT_ARB_FIXED_PRIO_EN
  assign start_c = '0;
`else
  logic [PTR_WIDTH-1:0] priority_q;
  logic [PTR_WIDTH-1:0] priority_d;

  assign start_c = (int'(priority_q) < int'(NUM_STATIONS)) ? priority_q : '0;
`endif

  // Downward scan leaves the lowest eligible index at/after start_c, and the lowest overall for wrap-around.
  always_comb begin
    win_found_c = 1'b0;
    any_c       = 1'b0;
    win_idx_c   = '0;
    wrap_idx_c  = '0;
    for (int i = int'(NUM_STATIONS) - 1; i >= 0; i--) begin
      if (eligible_c[i]) begin
        any_c      = 1'b1;
        wrap_idx_c = PTR_WIDTH'(i);
        if (i >= int'(start_c)) begin
          win_found_c = 1'b1;
          win_idx_c   = PTR_WIDTH'(i);
        end
      end
    end
    if (!win_found_c) begin
      win_idx_c = wrap_idx_c;
    end
  end

  always_comb begin
    granted_d = '0;
    bus_d     = '0;
    valid_d   = 1'b0;
`ifndef COMMIT_ARB_FIXED_PRIO_EN
    priority_d = priority_q;
`endif
    if (!iCommitStall && any_c) begin
      valid_d = 1'b1;
      for (int i = 0; i < int'(NUM_STATIONS); i++) begin
        if (win_idx_c == PTR_WIDTH'(i)) begin
          granted_d[i] = 1'b1;
          bus_d        = iCommitData[i*PACKET_WIDTH +: PACKET_WIDTH];
        end
      end
`ifndef COMMIT_ARB_FIXED_PRIO_EN
      priority_d = (int'(win_idx_c) == int'(NUM_STATIONS) - 1) ? '0 : win_idx_c + PTR_WIDTH'(1);
`endif
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oCommitGranted <= '0;
      oCommitBus     <= '0;
      oCommitValid   <= 1'b0;
`ifndef COMMIT_ARB_FIXED_PRIO_EN
      priority_q     <= '0;
`endif
    end else begin
      oCommitGranted <= granted_d;
      oCommitBus     <= bus_d;
      oCommitValid   <= valid_d;
`ifndef COMMIT_ARB_FIXED_PRIO_EN
      priority_q     <= priority_d;
`endif
    end
  end

endmodule

// File: tb/tb_commit_bus_arbiter.sv
// Directed self-checking bench for commit_bus_arbiter (4 stations, 16-bit packets).
// Expectations follow COMMIT_ARB_FIXED_PRIO_EN when the bench is built with it.
module tb_commit_bus_arbiter;

  localparam int unsigned NS = 4;
  localparam int unsigned PW = 16;

  logic              clk;
  logic              rst;
  logic [NS-1:0]     req;
  logic [NS*PW-1:0]  data;
  logic              stall;
  logic [NS-1:0]     granted;
  logic [PW-1:0]     bus;
  logic              valid;
  logic              busy;

  int checks;
  int failures;

  commit_bus_arbiter #(.NUM_STATIONS(NS), .PACKET_WIDTH(PW), .PTR_WIDTH(3)) dut (
    .Clock          (clk),
    .Reset          (rst),
    .iCommitRequest (req),
    .iCommitData    (data),
    .iCommitStall   (stall),
    .oCommitGranted (granted),
    .oCommitBus     (bus),
    .oCommitValid   (valid),
    .oBusy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pkt(input int k);
    return 16'hC0D0 + 16'(k * 16'h0111);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = '0;
    stall = 1'b0;
    rst   = 1'b1;
    step();
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    req   = '0;
    stall = 1'b0;
    rst   = 1'b1;
    step();
    step();
    checks++; if (granted !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", granted); end
    checks++; if (bus !== 16'h0000)    begin failures++; $display("FAIL reset_bus got=%h exp=0000", bus); end
    checks++; if (valid !== 1'b0)      begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0100;
    step();
    checks++; if (granted !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", granted); end
    checks++; if (bus !== pkt(2))      begin failures++; $display("FAIL single_bus got=%h exp=%h", bus, pkt(2)); end
    checks++; if (valid !== 1'b1)      begin failures++; $display("FAIL single_valid got=%b exp=1", valid); end
    checks++; if (busy !== 1'b1)       begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    step();
    checks++; if (granted !== 4'b0000) begin failures++; $display("FAIL masked_grant got=%b exp=0000", granted); end
    checks++; if (valid !== 1'b0)      begin failures++; $display("FAIL masked_valid got=%b exp=0", valid); end
    checks++; if (bus !== 16'h0000)    begin failures++; $display("FAIL masked_bus got=%h exp=0000", bus); end
    req = '0;
    step();
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_all_requests();
    logic [NS-1:0] exp_g;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      step();
`ifdef COMMIT_ARB_FIXED_PRIO_EN
      exp_g = (c % 2 == 0) ? 4'b0001 : 4'b0010;
`else
      exp_g = 4'(1 << (c % 4));
`endif
      checks++; if (granted !== exp_g) begin failures++; $display("FAIL all_grant c=%0d got=%b exp=%b", c, granted, exp_g); end
      checks++; if (valid !== 1'b1)    begin failures++; $display("FAIL all_valid c=%0d got=%b exp=1", c, valid); end
    end
    req = '0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [NS-1:0] exp_g;
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      step();
      exp_g = (c % 2 == 0) ? 4'b0010 : 4'b0000;
      checks++; if (granted !== exp_g) begin failures++; $display("FAIL b2b_grant c=%0d got=%b exp=%b", c, granted, exp_g); end
    end
    req = '0;
    step();
  endtask

  task automatic test_stall();
    logic [NS-1:0] exp_g;
    do_reset();
    req = 4'b0001;
    step();
    req   = 4'b0011;
    stall = 1'b1;
    #1;
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL stall_inflight_valid got=%b exp=1", valid); end
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (granted !== 4'b0000) begin failures++; $display("FAIL stall_grant c=%0d got=%b exp=0000", c, granted); end
      checks++; if (bus !== 16'h0000)    begin failures++; $display("FAIL stall_bus c=%0d got=%h exp=0000", c, bus); end
      checks++; if (busy !== 1'b1)       begin failures++; $display("FAIL stall_busy c=%0d got=%b exp=1", c, busy); end
    end
    stall = 1'b0;
    step();
`ifdef COMMIT_ARB_FIXED_PRIO_EN
    exp_g = 4'b0001;
`else
    exp_g = 4'b0010;
`endif
    checks++; if (granted !== exp_g) begin failures++; $display("FAIL unstall_grant got=%b exp=%b", granted, exp_g); end
    req = '0;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b0001;
    step();
    req = 4'b1000;
    step();
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL pre_reset_valid got=%b exp=1", valid); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (granted !== 4'b0000) begin failures++; $display("FAIL async_grant got=%b exp=0000", granted); end
    checks++; if (valid !== 1'b0)      begin failures++; $display("FAIL async_valid got=%b exp=0", valid); end
    checks++; if (bus !== 16'h0000)    begin failures++; $display("FAIL async_bus got=%h exp=0000", bus); end
    rst = 1'b0;
    step();
    checks++; if (granted !== 4'b1000) begin failures++; $display("FAIL post_reset_grant got=%b exp=1000", granted); end
    checks++; if (bus !== pkt(3))      begin failures++; $display("FAIL post_reset_bus got=%h exp=%h", bus, pkt(3)); end
    req = '0;
    step();
  endtask

  task automatic test_withdraw();
    do_reset();
    req = 4'b0011;
    step();
    checks++; if (granted !== 4'b0001) begin failures++; $display("FAIL withdraw_first got=%b exp=0001", granted); end
    req = 4'b0001;
    step();
    checks++; if (granted !== 4'b0000) begin failures++; $display("FAIL withdraw_second got=%b exp=0000", granted); end
    req = '0;
    step();
  endtask

  task automatic test_pair_1010();
    logic [NS-1:0] exp_g;
    do_reset();
    req = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      step();
      exp_g = (c % 2 == 0) ? 4'b0010 : 4'b1000;
      checks++; if (granted !== exp_g) begin failures++; $display("FAIL pair_grant c=%0d got=%b exp=%b", c, granted, exp_g); end
    end
    req = '0;
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    req      = '0;
    stall    = 1'b0;
    for (int k = 0; k < int'(NS); k++) data[k*PW +: PW] = pkt(k);
    test_reset();
    test_single();
    test_all_requests();
    test_back_to_back();
    test_stall();
    test_async_reset();
    test_withdraw();
    test_pair_1010();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
